// File: rtl/axi_lite_reg_slave_if.sv
// AXI4-Lite bus bundle between the core's axi_master and the peripheral register slave.
// Fixed 32-bit data/address; clock and reset stay outside the bundle.
interface axi_lite_reg_slave_if;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;

  modport slave (
    input  S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    output S_AXI_AWREADY,
    input  S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    output S_AXI_WREADY,
    output S_AXI_BVALID, S_AXI_BRESP,
    input  S_AXI_BREADY,
    input  S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    output S_AXI_ARREADY,
    output S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWVALID, S_AXI_AWADDR, S_AXI_AWPROT,
    input  S_AXI_AWREADY,
    output S_AXI_WVALID, S_AXI_WDATA, S_AXI_WSTRB,
    input  S_AXI_WREADY,
    input  S_AXI_BVALID, S_AXI_BRESP,
    output S_AXI_BREADY,
    output S_AXI_ARVALID, S_AXI_ARADDR, S_AXI_ARPROT,
    input  S_AXI_ARREADY,
    input  S_AXI_RVALID, S_AXI_RDATA, S_AXI_RRESP,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: NUM_RW byte-writable registers plus NUM_RO read-only words.
// AW and W are captured independently; the write commits on the edge the second one lands.
module axi_lite_reg_slave #(
  parameter int ADDR_W = 12,
  parameter int NUM_RW = 4,
  parameter int NUM_RO = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  axi_lite_reg_slave_if.slave    s_axi,
  output logic [32*NUM_RW-1:0]   rw_regs,
  output logic [NUM_RW-1:0]      wr_strobe,
  input  logic [32*NUM_RO-1:0]   ro_words
);

  localparam int IDX_W     = ADDR_W - 2;
  localparam int NUM_WORDS = NUM_RW + NUM_RO;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ---------------- write path ----------------
  logic             aw_flag_reg, aw_flag_next;
  logic             w_flag_reg, w_flag_next;
  logic [IDX_W-1:0] aw_idx_reg;
  logic [31:0]      w_data_reg;
  logic [3:0]       w_strb_reg;
  logic             awready_reg, awready_next;
  logic             wready_reg, wready_next;
  logic             bvalid_reg, bvalid_next;
  logic [1:0]       bresp_reg, bresp_next;

  logic             aw_hs, w_hs, commit, wr_in_rw;
  logic [IDX_W-1:0] wr_idx;
  logic [31:0]      wr_data;
  logic [3:0]       wr_strb;

  // Values landing this edge bypass the capture registers so a same-edge AW+W commits at once.
  always_comb begin
    aw_hs    = s_axi.S_AXI_AWVALID && awready_reg;
    w_hs     = s_axi.S_AXI_WVALID && wready_reg;
    wr_idx   = aw_hs ? s_axi.S_AXI_AWADDR[ADDR_W-1:2] : aw_idx_reg;
    wr_data  = w_hs ? s_axi.S_AXI_WDATA : w_data_reg;
    wr_strb  = w_hs ? s_axi.S_AXI_WSTRB : w_strb_reg;
    commit   = (aw_hs || aw_flag_reg) && (w_hs || w_flag_reg);
    wr_in_rw = wr_idx < IDX_W'(NUM_RW);

    aw_flag_next = commit ? 1'b0 : (aw_flag_reg || aw_hs);
    w_flag_next  = commit ? 1'b0 : (w_flag_reg || w_hs);

    bvalid_next = bvalid_reg;
    bresp_next  = bresp_reg;
    if (commit) begin
      bvalid_next = 1'b1;
      bresp_next  = wr_in_rw ? RESP_OKAY : RESP_SLVERR;
    end else if (s_axi.S_AXI_BREADY) begin
      bvalid_next = 1'b0;
    end

    awready_next = !aw_flag_next && !bvalid_next;
    wready_next  = !w_flag_next && !bvalid_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aw_flag_reg <= 1'b0;
      w_flag_reg  <= 1'b0;
      aw_idx_reg  <= '0;
      w_data_reg  <= '0;
      w_strb_reg  <= '0;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
    end else begin
      aw_flag_reg <= aw_flag_next;
      w_flag_reg  <= w_flag_next;
      awready_reg <= awready_next;
      wready_reg  <= wready_next;
      bvalid_reg  <= bvalid_next;
      bresp_reg   <= bresp_next;
      if (aw_hs) aw_idx_reg <= s_axi.S_AXI_AWADDR[ADDR_W-1:2];
      if (w_hs) begin
        w_data_reg <= s_axi.S_AXI_WDATA;
        w_strb_reg <= s_axi.S_AXI_WSTRB;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_rw
    logic [31:0] word_reg;
    logic        strobe_reg;
    logic        hit;

    assign hit = commit && (wr_idx == IDX_W'(gi));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        word_reg   <= '0;
        strobe_reg <= 1'b0;
      end else begin
        strobe_reg <= hit;
        if (hit) begin
          for (int b = 0; b < 4; b++) begin
            if (wr_strb[b]) word_reg[8*b +: 8] <= wr_data[8*b +: 8];
          end
        end
      end
    end

    assign rw_regs[32*gi +: 32] = word_reg;
    assign wr_strobe[gi]        = strobe_reg;
  end

  // ---------------- read path ----------------
  logic             arready_reg, arready_next;
  logic             rvalid_reg, rvalid_next;
  logic [31:0]      rdata_reg;
  logic [1:0]       rresp_reg;
  logic             ar_hs, rd_hit;
  logic [IDX_W-1:0] ar_idx;
  logic [31:0]      rd_sel;
  logic [32*NUM_WORDS-1:0] rd_flat;

  assign rd_flat = {ro_words, rw_regs};

  always_comb begin
    ar_hs  = s_axi.S_AXI_ARVALID && arready_reg;
    ar_idx = s_axi.S_AXI_ARADDR[ADDR_W-1:2];
    rd_sel = '0;
    rd_hit = 1'b0;
    for (int k = 0; k < NUM_WORDS; k++) begin
      if (ar_idx == IDX_W'(k)) begin
        rd_sel = rd_flat[32*k +: 32];
        rd_hit = 1'b1;
      end
    end

    rvalid_next = rvalid_reg;
    if (ar_hs)
      rvalid_next = 1'b1;
    else if (s_axi.S_AXI_RREADY)
      rvalid_next = 1'b0;
    arready_next = !rvalid_next;
  end

  // rw_regs are flop outputs, so a same-edge write is not yet visible here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      arready_reg <= arready_next;
      rvalid_reg  <= rvalid_next;
      if (ar_hs) begin
        rdata_reg <= rd_hit ? rd_sel : 32'h0;
        rresp_reg <= rd_hit ? RESP_OKAY : RESP_SLVERR;
      end
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_reg;
  assign s_axi.S_AXI_WREADY  = wready_reg;
  assign s_axi.S_AXI_BVALID  = bvalid_reg;
  assign s_axi.S_AXI_BRESP   = bresp_reg;
  assign s_axi.S_AXI_ARREADY = arready_reg;
  assign s_axi.S_AXI_RVALID  = rvalid_reg;
  assign s_axi.S_AXI_RDATA   = rdata_reg;
  assign s_axi.S_AXI_RRESP   = rresp_reg;

  logic unused_bits;
  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                         s_axi.S_AXI_AWADDR[31:ADDR_W], s_axi.S_AXI_AWADDR[1:0],
                         s_axi.S_AXI_ARADDR[31:ADDR_W], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: stimulus pushes expected B/R responses,
// a negedge monitor pops and compares them whenever the DUT presents a response.
module tb_axi_lite_reg_slave;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] rw_regs;
  logic [3:0]   wr_strobe;
  logic [63:0]  ro_words;

  axi_lite_reg_slave_if axi();

  axi_lite_reg_slave dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .s_axi     (axi.slave),
    .rw_regs   (rw_regs),
    .wr_strobe (wr_strobe),
    .ro_words  (ro_words)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [1:0]  b_q [$];
  logic [33:0] r_q [$];

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Response monitor: first sight of a VALID pops the queue, later cycles check it is held.
  initial begin
    logic       b_seen, r_seen;
    logic [1:0] b_cur;
    logic [33:0] r_cur;
    b_seen = 1'b0;
    r_seen = 1'b0;
    b_cur  = '0;
    r_cur  = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        b_seen = 1'b0;
        r_seen = 1'b0;
      end else begin
        if (axi.S_AXI_BVALID) begin
          if (!b_seen) begin
            b_seen = 1'b1;
            if (b_q.size() == 0) begin
              checks++;
              errors++;
              b_cur = axi.S_AXI_BRESP;
              $display("FAIL b_unexpected: got BVALID=1 BRESP=%0h expected no write response", axi.S_AXI_BRESP);
            end else begin
              b_cur = b_q.pop_front();
              check("bresp", 128'(axi.S_AXI_BRESP), 128'(b_cur));
            end
          end else begin
            check("bresp_hold", 128'(axi.S_AXI_BRESP), 128'(b_cur));
          end
          if (axi.S_AXI_BREADY) b_seen = 1'b0;
        end
        if (axi.S_AXI_RVALID) begin
          if (!r_seen) begin
            r_seen = 1'b1;
            if (r_q.size() == 0) begin
              checks++;
              errors++;
              r_cur = {axi.S_AXI_RDATA, axi.S_AXI_RRESP};
              $display("FAIL r_unexpected: got RVALID=1 RDATA=%0h expected no read response", axi.S_AXI_RDATA);
            end else begin
              r_cur = r_q.pop_front();
              check("rdata_rresp", 128'({axi.S_AXI_RDATA, axi.S_AXI_RRESP}), 128'(r_cur));
            end
          end else begin
            check("rdata_rresp_hold", 128'({axi.S_AXI_RDATA, axi.S_AXI_RRESP}), 128'(r_cur));
          end
          if (axi.S_AXI_RREADY) r_seen = 1'b0;
        end
      end
    end
  end

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] resp);
    logic aw_pend, w_pend, aw_hit, w_hit;
    int   n;
    b_q.push_back(resp);
    axi.S_AXI_AWADDR  = addr;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA   = data;
    axi.S_AXI_WSTRB   = strb;
    axi.S_AXI_WVALID  = 1'b1;
    aw_pend = 1'b1;
    w_pend  = 1'b1;
    n = 0;
    while ((aw_pend || w_pend) && n < 20) begin
      aw_hit = aw_pend && axi.S_AXI_AWREADY;
      w_hit  = w_pend && axi.S_AXI_WREADY;
      tick();
      n++;
      if (aw_hit) begin aw_pend = 1'b0; axi.S_AXI_AWVALID = 1'b0; end
      if (w_hit)  begin w_pend  = 1'b0; axi.S_AXI_WVALID  = 1'b0; end
    end
    if (aw_pend || w_pend) begin
      checks++;
      errors++;
      $display("FAIL write_timeout: addr %0h still pending aw=%0b w=%0b expected accepted", addr, aw_pend, w_pend);
      axi.S_AXI_AWVALID = 1'b0;
      axi.S_AXI_WVALID  = 1'b0;
    end
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] resp);
    logic hit;
    int   n;
    r_q.push_back({data, resp});
    axi.S_AXI_ARADDR  = addr;
    axi.S_AXI_ARVALID = 1'b1;
    hit = 1'b0;
    n = 0;
    while (!hit && n < 20) begin
      hit = axi.S_AXI_ARREADY;
      tick();
      n++;
    end
    axi.S_AXI_ARVALID = 1'b0;
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: addr %0h ARREADY=0 expected accepted", addr);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((b_q.size() != 0 || r_q.size() != 0 || axi.S_AXI_BVALID || axi.S_AXI_RVALID) && n < 50) begin
      tick();
      n++;
    end
    if (b_q.size() != 0 || r_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got b_pending=%0d r_pending=%0d expected 0", b_q.size(), r_q.size());
      b_q.delete();
      r_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_AWADDR  = '0;
    axi.S_AXI_AWPROT  = '0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_WDATA   = '0;
    axi.S_AXI_WSTRB   = '0;
    axi.S_AXI_BREADY  = 1'b0;
    axi.S_AXI_ARVALID = 1'b0;
    axi.S_AXI_ARADDR  = '0;
    axi.S_AXI_ARPROT  = '0;
    axi.S_AXI_RREADY  = 1'b0;
    ro_words = {32'h0BAD_BEEF, 32'hCAFE_F00D};

    // 1: reset values and READY rise
    repeat (3) tick();
    check("rst_awready", 128'(axi.S_AXI_AWREADY), 128'd0);
    check("rst_wready", 128'(axi.S_AXI_WREADY), 128'd0);
    check("rst_arready", 128'(axi.S_AXI_ARREADY), 128'd0);
    check("rst_bvalid_bresp", 128'({axi.S_AXI_BVALID, axi.S_AXI_BRESP}), 128'd0);
    check("rst_rvalid_rresp", 128'({axi.S_AXI_RVALID, axi.S_AXI_RRESP}), 128'd0);
    check("rst_rdata", 128'(axi.S_AXI_RDATA), 128'd0);
    check("rst_rw_regs", rw_regs, 128'd0);
    check("rst_wr_strobe", 128'(wr_strobe), 128'd0);
    reset_n = 1'b1;
    tick();
    check("ready_after_rst", 128'({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}), 128'b111);

    // 2: AW+W same cycle, partial strobe, B held under backpressure
    b_q.push_back(2'b00);
    axi.S_AXI_AWADDR  = 32'h004;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WDATA   = 32'hA1B2_C3D4;
    axi.S_AXI_WSTRB   = 4'b0101;
    axi.S_AXI_WVALID  = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    check("t2_reg1", 128'(rw_regs[63:32]), 128'h00B2_00D4);
    check("t2_strobe", 128'(wr_strobe), 128'b0010);
    check("t2_bvalid", 128'(axi.S_AXI_BVALID), 128'd1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t2_ready_low", 128'({axi.S_AXI_AWREADY, axi.S_AXI_WREADY}), 128'b00);
      check("t2_bvalid_held", 128'(axi.S_AXI_BVALID), 128'd1);
      if (i == 0) check("t2_strobe_off", 128'(wr_strobe), 128'd0);
    end
    axi.S_AXI_BREADY = 1'b1;
    tick();
    check("t2_after_b", 128'({axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}), 128'b011);

    // 3: W three cycles ahead of AW
    axi.S_AXI_WDATA  = 32'h1234_5678;
    axi.S_AXI_WSTRB  = 4'hF;
    axi.S_AXI_WVALID = 1'b1;
    tick();
    axi.S_AXI_WVALID = 1'b0;
    check("t3_w_captured", 128'({axi.S_AXI_WREADY, axi.S_AXI_AWREADY, axi.S_AXI_BVALID}), 128'b010);
    check("t3_no_early_commit", 128'(rw_regs[31:0]), 128'd0);
    tick();
    tick();
    b_q.push_back(2'b00);
    axi.S_AXI_AWADDR  = 32'h000;
    axi.S_AXI_AWVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    check("t3_reg0", 128'(rw_regs[31:0]), 128'h1234_5678);
    check("t3_strobe", 128'(wr_strobe), 128'b0001);
    wait_drain();

    // 4: read-only word sampled at AR, held under backpressure
    axi.S_AXI_RREADY = 1'b0;
    do_read(32'h010, 32'hCAFE_F00D, 2'b00);
    check("t4_rvalid_arready", 128'({axi.S_AXI_RVALID, axi.S_AXI_ARREADY}), 128'b10);
    ro_words[31:0] = 32'h1111_1111;
    repeat (3) tick();
    axi.S_AXI_RREADY = 1'b1;
    tick();
    check("t4_after_r", 128'({axi.S_AXI_RVALID, axi.S_AXI_ARREADY}), 128'b01);
    do_read(32'h004, 32'h00B2_00D4, 2'b00);
    do_read(32'h014, 32'h0BAD_BEEF, 2'b00);
    wait_drain();

    // 5: error decode, zero strobe, upper address bits, same-edge read/write
    do_write(32'h010, 32'hFFFF_FFFF, 4'hF, 2'b10);
    check("t5_ro_wr_strobe", 128'(wr_strobe), 128'd0);
    check("t5_ro_wr_regs", rw_regs, {32'h0, 32'h0, 32'h00B2_00D4, 32'h1234_5678});
    wait_drain();
    do_write(32'h008, 32'hFFFF_FFFF, 4'h0, 2'b00);
    check("t5_strb0_strobe", 128'(wr_strobe), 128'b0100);
    check("t5_strb0_reg2", 128'(rw_regs[95:64]), 128'd0);
    wait_drain();
    do_read(32'h018, 32'h0, 2'b10);
    do_read(32'hFFC, 32'h0, 2'b10);
    do_read(32'h1004, 32'h00B2_00D4, 2'b00);
    wait_drain();
    b_q.push_back(2'b00);
    r_q.push_back({32'h1234_5678, 2'b00});
    axi.S_AXI_AWADDR  = 32'h000;
    axi.S_AXI_WDATA   = 32'hDEAD_BEEF;
    axi.S_AXI_WSTRB   = 4'hF;
    axi.S_AXI_ARADDR  = 32'h000;
    axi.S_AXI_AWVALID = 1'b1;
    axi.S_AXI_WVALID  = 1'b1;
    axi.S_AXI_ARVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    axi.S_AXI_WVALID  = 1'b0;
    axi.S_AXI_ARVALID = 1'b0;
    check("t5_same_edge_reg0", 128'(rw_regs[31:0]), 128'hDEAD_BEEF);
    wait_drain();
    do_read(32'h000, 32'hDEAD_BEEF, 2'b00);
    wait_drain();

    // 6: reset with AW captured and W pending
    axi.S_AXI_AWADDR  = 32'h00C;
    axi.S_AXI_AWVALID = 1'b1;
    tick();
    axi.S_AXI_AWVALID = 1'b0;
    check("t6_aw_captured", 128'({axi.S_AXI_AWREADY, axi.S_AXI_WREADY}), 128'b01);
    reset_n = 1'b0;
    #1;
    check("t6_rst_regs", rw_regs, 128'd0);
    check("t6_rst_outputs", 128'({axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}), 128'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check("t6_ready_after_rst", 128'({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}), 128'b111);
    repeat (5) tick();
    do_write(32'h00C, 32'h55AA_55AA, 4'hF, 2'b00);
    check("t6_reg3", 128'(rw_regs[127:96]), 128'h55AA_55AA);
    check("t6_strobe", 128'(wr_strobe), 128'b1000);
    wait_drain();
    do_read(32'h00C, 32'h55AA_55AA, 2'b00);
    wait_drain();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
